// File: rtl/axi_burst_mem_slave.sv
// AXI burst memory endpoint: AW/W/B and AR/R served from a word memory.
// Optional byte-strobe writes when AXI_MEM_SLAVE_WSTRB_EN is defined.
module axi_burst_mem_slave #(
  parameter int AXI_ID_WIDTH      = 1,
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int AXI_ADDR_WIDTH    = 8,
  parameter int MEM_DEPTH         = 16,
  parameter int AXI_AWCHAN_WIDTH  = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 13,
  parameter int AXI_WDCHAN_WIDTH  = AXI_DATA_WIDTH + AXI_DATA_WIDTH/8 + 1,
  parameter int AXI_WBCHAN_WIDTH  = AXI_ID_WIDTH + 2,
  parameter int AXI_ARCHAN_WIDTH  = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 13,
  parameter int AXI_RDCHANB_WIDTH = AXI_ID_WIDTH + AXI_DATA_WIDTH + 3
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [AXI_AWCHAN_WIDTH-1:0]  S_AXI_AWCH_i,
  input  logic                         S_AXI_AWCH_VALID_i,
  output logic                         S_AXI_AWCH_READY_o,
  input  logic [AXI_WDCHAN_WIDTH-1:0]  S_AXI_WCH_i,
  input  logic                         S_AXI_WCH_VALID_i,
  output logic                         S_AXI_WCH_READY_o,
  output logic [AXI_WBCHAN_WIDTH-1:0]  S_AXI_BCH_o,
  output logic                         S_AXI_BCH_VALID_o,
  input  logic                         S_AXI_BCH_READY_i,
  input  logic [AXI_ARCHAN_WIDTH-1:0]  S_AXI_ARCH_i,
  input  logic                         S_AXI_ARCH_VALID_i,
  output logic                         S_AXI_ARCH_READY_o,
  output logic [AXI_RDCHANB_WIDTH-1:0] S_AXI_RCH_o,
  output logic                         S_AXI_RCH_VALID_o,
  input  logic                         S_AXI_RCH_READY_i
);

  localparam int AW  = AXI_ADDR_WIDTH;
  localparam int IDW = AXI_ID_WIDTH;
  localparam int DW  = AXI_DATA_WIDTH;
  localparam int SW  = DW / 8;
  localparam int LSB = $clog2(SW);
  localparam int IW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  // Next word index for a normalised burst type (00/01/10).
  function automatic logic [IW-1:0] nxt_idx(
    input logic [IW-1:0] idx,
    input logic [1:0]    bt,
    input logic [7:0]    len
  );
    logic [IW-1:0] m;
    logic [IW-1:0] inc;
    m   = IW'(len);
    inc = idx + IW'(1);
    case (bt)
      2'b00:   nxt_idx = idx;
      2'b10:   nxt_idx = (idx & ~m) | (inc & m);
      default: nxt_idx = inc;
    endcase
  endfunction

  // Reserved type or WRAP with an unsupported length.
  function automatic logic bad_burst(
    input logic [1:0] bt,
    input logic [7:0] len
  );
    logic wl;
    wl = (len == 8'd1) || (len == 8'd3) ||
         (len == 8'd7) || (len == 8'd15);
    bad_burst = (bt == 2'b11) || ((bt == 2'b10) && !wl);
  endfunction

  logic [DW-1:0] mem_q [MEM_DEPTH];

  logic [AW-1:0]  aw_addr;
  logic [1:0]     aw_bt;
  logic [7:0]     aw_len;
  logic [IDW-1:0] aw_id;
  logic [AW-1:0]  ar_addr;
  logic [1:0]     ar_bt;
  logic [7:0]     ar_len;
  logic [IDW-1:0] ar_id;
  logic [IW-1:0]  aw_idx;
  logic [IW-1:0]  ar_idx;
  logic           aw_bad;
  logic           ar_bad;
  logic [DW-1:0]  w_data;
  logic [SW-1:0]  w_strb;
  logic           w_last;
  logic           unused_ok;

  assign aw_addr = S_AXI_AWCH_i[AW-1:0];
  assign aw_bt   = S_AXI_AWCH_i[AW+1:AW];
  assign aw_len  = S_AXI_AWCH_i[AW+12:AW+5];
  assign aw_id   = S_AXI_AWCH_i[AW+13 +: IDW];
  assign ar_addr = S_AXI_ARCH_i[AW-1:0];
  assign ar_bt   = S_AXI_ARCH_i[AW+1:AW];
  assign ar_len  = S_AXI_ARCH_i[AW+12:AW+5];
  assign ar_id   = S_AXI_ARCH_i[AW+13 +: IDW];
  assign aw_idx  = aw_addr[LSB +: IW];
  assign ar_idx  = ar_addr[LSB +: IW];
  assign aw_bad  = bad_burst(aw_bt, aw_len);
  assign ar_bad  = bad_burst(ar_bt, ar_len);
  assign w_last  = S_AXI_WCH_i[0];
  assign w_strb  = S_AXI_WCH_i[SW:1];
  assign w_data  = S_AXI_WCH_i[SW+1 +: DW];

  assign unused_ok = ^{S_AXI_AWCH_i, S_AXI_ARCH_i, S_AXI_WCH_i};

  // READYs stay low for one cycle after reset is released.
  logic rdy_q;
  always_ff @(posedge ACLK) begin
    if (ARESET) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

  // ---------------- write path ----------------
  w_state_t       w_st_q,  w_st_d;
  logic [IDW-1:0] wid_q,   wid_d;
  logic [7:0]     wlen_q,  wlen_d;
  logic [1:0]     wbt_q,   wbt_d;
  logic [IW-1:0]  widx_q,  widx_d;
  logic [8:0]     wcnt_q,  wcnt_d;
  logic           werr_q,  werr_d;
  logic           mem_we;

  assign S_AXI_AWCH_READY_o = rdy_q && (w_st_q == W_IDLE);
  assign S_AXI_WCH_READY_o  = (w_st_q == W_DATA);
  assign S_AXI_BCH_VALID_o  = (w_st_q == W_RESP);
  assign S_AXI_BCH_o = {(werr_q ? 2'b10 : 2'b00), wid_q};

  // Write FSM next state, burst bookkeeping and memory write enable.
  always_comb begin
    w_st_d = w_st_q;
    wid_d  = wid_q;
    wlen_d = wlen_q;
    wbt_d  = wbt_q;
    widx_d = widx_q;
    wcnt_d = wcnt_q;
    werr_d = werr_q;
    mem_we = 1'b0;
    case (w_st_q)
      W_IDLE: begin
        if (S_AXI_AWCH_READY_o && S_AXI_AWCH_VALID_i) begin
          wid_d  = aw_id;
          wlen_d = aw_len;
          wbt_d  = aw_bad ? 2'b01 : aw_bt;
          widx_d = aw_idx;
          wcnt_d = 9'd0;
          werr_d = aw_bad;
          w_st_d = W_DATA;
        end
      end
      W_DATA: begin
        if (S_AXI_WCH_VALID_i) begin
          mem_we = (wcnt_q <= {1'b0, wlen_q});
          widx_d = nxt_idx(widx_q, wbt_q, wlen_q);
          if (wcnt_q != 9'h1FF) wcnt_d = wcnt_q + 9'd1;
          if (w_last) begin
            w_st_d = W_RESP;
            if (wcnt_q != {1'b0, wlen_q}) werr_d = 1'b1;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BCH_READY_i) w_st_d = W_IDLE;
      end
      default: w_st_d = W_IDLE;
    endcase
  end

  // Write FSM registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_st_q <= W_IDLE;
      wid_q  <= '0;
      wlen_q <= '0;
      wbt_q  <= '0;
      widx_q <= '0;
      wcnt_q <= '0;
      werr_q <= 1'b0;
    end else begin
      w_st_q <= w_st_d;
      wid_q  <= wid_d;
      wlen_q <= wlen_d;
      wbt_q  <= wbt_d;
      widx_q <= widx_d;
      wcnt_q <= wcnt_d;
      werr_q <= werr_d;
    end
  end

  // Memory write port; contents are never reset.
  always_ff @(posedge ACLK) begin
    if (mem_we && !ARESET) begin
`ifdef AXI_MEM_SLAVE_WSTRB_EN
      for (int b = 0; b < SW; b++) begin
        if (w_strb[b]) mem_q[widx_q][b*8 +: 8] <= w_data[b*8 +: 8];
      end
`else
      mem_q[widx_q] <= w_data;
`endif
    end
  end

  // ---------------- read path ----------------
  r_state_t       r_st_q,  r_st_d;
  logic [IDW-1:0] rid_q,   rid_d;
  logic [7:0]     rlen_q,  rlen_d;
  logic [1:0]     rbt_q,   rbt_d;
  logic [IW-1:0]  ridx_q,  ridx_d;
  logic [7:0]     rcnt_q,  rcnt_d;
  logic           rerr_q,  rerr_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           rlast_q, rlast_d;
  logic [IW-1:0]  r_nidx;

  assign r_nidx = nxt_idx(ridx_q, rbt_q, rlen_q);
  assign S_AXI_ARCH_READY_o = rdy_q && (r_st_q == R_IDLE);
  assign S_AXI_RCH_VALID_o  = (r_st_q == R_DATA);
  assign S_AXI_RCH_o = {rdata_q, (rerr_q ? 2'b10 : 2'b00),
                        rlast_q, rid_q};

  // Read FSM: the R register is loaded ahead of each beat.
  always_comb begin
    r_st_d  = r_st_q;
    rid_d   = rid_q;
    rlen_d  = rlen_q;
    rbt_d   = rbt_q;
    ridx_d  = ridx_q;
    rcnt_d  = rcnt_q;
    rerr_d  = rerr_q;
    rdata_d = rdata_q;
    rlast_d = rlast_q;
    case (r_st_q)
      R_IDLE: begin
        if (S_AXI_ARCH_READY_o && S_AXI_ARCH_VALID_i) begin
          rid_d   = ar_id;
          rlen_d  = ar_len;
          rbt_d   = ar_bad ? 2'b01 : ar_bt;
          rerr_d  = ar_bad;
          ridx_d  = ar_idx;
          rcnt_d  = 8'd0;
          rdata_d = mem_q[ar_idx];
          rlast_d = (ar_len == 8'd0);
          r_st_d  = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RCH_READY_i) begin
          if (rlast_q) begin
            r_st_d = R_IDLE;
          end else begin
            ridx_d  = r_nidx;
            rdata_d = mem_q[r_nidx];
            rcnt_d  = rcnt_q + 8'd1;
            rlast_d = ((rcnt_q + 8'd1) == rlen_q);
          end
        end
      end
      default: r_st_d = R_IDLE;
    endcase
  end

  // Read FSM registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_st_q  <= R_IDLE;
      rid_q   <= '0;
      rlen_q  <= '0;
      rbt_q   <= '0;
      ridx_q  <= '0;
      rcnt_q  <= '0;
      rerr_q  <= 1'b0;
      rdata_q <= '0;
      rlast_q <= 1'b0;
    end else begin
      r_st_q  <= r_st_d;
      rid_q   <= rid_d;
      rlen_q  <= rlen_d;
      rbt_q   <= rbt_d;
      ridx_q  <= ridx_d;
      rcnt_q  <= rcnt_d;
      rerr_q  <= rerr_d;
      rdata_q <= rdata_d;
      rlast_q <= rlast_d;
    end
  end

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Scoreboard bench for axi_burst_mem_slave with a word-array model.
// Strobe checks follow AXI_MEM_SLAVE_WSTRB_EN.
module tb_axi_burst_mem_slave;

  logic        ACLK;
  logic        ARESET;
  logic [21:0] awch;
  logic        awv;
  logic        awr;
  logic [36:0] wch;
  logic        wv;
  logic        wr;
  logic [2:0]  bch;
  logic        bv;
  logic        br;
  logic [21:0] arch;
  logic        arv;
  logic        arr;
  logic [35:0] rch;
  logic        rv;
  logic        rr;

  axi_burst_mem_slave dut (
    .ACLK               (ACLK),
    .ARESET             (ARESET),
    .S_AXI_AWCH_i       (awch),
    .S_AXI_AWCH_VALID_i (awv),
    .S_AXI_AWCH_READY_o (awr),
    .S_AXI_WCH_i        (wch),
    .S_AXI_WCH_VALID_i  (wv),
    .S_AXI_WCH_READY_o  (wr),
    .S_AXI_BCH_o        (bch),
    .S_AXI_BCH_VALID_o  (bv),
    .S_AXI_BCH_READY_i  (br),
    .S_AXI_ARCH_i       (arch),
    .S_AXI_ARCH_VALID_i (arv),
    .S_AXI_ARCH_READY_o (arr),
    .S_AXI_RCH_o        (rch),
    .S_AXI_RCH_VALID_o  (rv),
    .S_AXI_RCH_READY_i  (rr)
  );

  int n_chk;
  int n_fail;
  logic [2:0]  bq [$];
  logic [35:0] rq [$];
  logic [31:0] mm [16];

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [21:0] ax(input logic [0:0] id,
    input logic [7:0] len, input logic [1:0] bt,
    input logic [7:0] addr);
    return {id, len, 3'b010, bt, addr};
  endfunction

  function automatic bit wrap_ok(input int len);
    return len == 1 || len == 3 || len == 7 || len == 15;
  endfunction

  function automatic bit is_bad(input int bt, input int len);
    return bt == 3 || (bt == 2 && !wrap_ok(len));
  endfunction

  // Next word index from the burst rules, written arithmetically.
  function automatic int mnext(input int idx, input int bt,
                               input int len);
    int blk;
    int base;
    if (bt == 0) return idx;
    if (bt == 2 && wrap_ok(len)) begin
      blk  = len + 1;
      base = idx - (idx % blk);
      return base + ((idx - base + 1) % blk);
    end
    return (idx + 1) % 16;
  endfunction

  // Monitor: checks every presented B/R beat against the queue head.
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (bv) begin
        if (bq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL b_unexpected: got %h expected none", bch);
        end else begin
          chk("b_beat", 64'(bch), 64'(bq[0]));
          if (br) void'(bq.pop_front());
        end
      end
      if (rv) begin
        if (rq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL r_unexpected: got %h expected none", rch);
        end else begin
          chk("r_beat", 64'(rch), 64'(rq[0]));
          if (rr) void'(rq.pop_front());
        end
      end
    end
  end

  // Random back-pressure on B and R.
  initial begin
    rr = 1'b0;
    br = 1'b0;
    forever begin
      @(posedge ACLK);
      #1;
      rr = ($urandom_range(0, 3) != 0);
      br = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 600; i++) begin
      if (bq.size() == 0 && rq.size() == 0) break;
      @(negedge ACLK);
    end
    n_chk++;
    if (bq.size() != 0 || rq.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: got b=%0d r=%0d pending expected 0",
               nm, bq.size(), rq.size());
      bq.delete();
      rq.delete();
    end
    repeat (2) @(posedge ACLK);
    #1;
  endtask

  task automatic aw_send(input logic [21:0] v);
    awch = v;
    awv  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge ACLK);
      if (awr) break;
    end
    if (!awr) chk("aw_ready_timeout", 64'(awr), 64'd1);
    @(posedge ACLK);
    #1;
    awv = 1'b0;
  endtask

  task automatic ar_send(input logic [21:0] v);
    arch = v;
    arv  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge ACLK);
      if (arr) break;
    end
    if (!arr) chk("ar_ready_timeout", 64'(arr), 64'd1);
    @(posedge ACLK);
    #1;
    arv = 1'b0;
  endtask

  task automatic do_write(input logic [0:0] id, input int len,
    input int bt, input int addr, input int nbeats,
    input logic [31:0] dbase, input logic [3:0] sfix, input bit rnd);
    int idx;
    logic [31:0] d;
    logic [3:0]  s;
    logic [1:0]  resp;
    resp = (is_bad(bt, len) || nbeats != len + 1) ? 2'b10 : 2'b00;
    bq.push_back({resp, id});
    aw_send(ax(id, 8'(len), 2'(bt), 8'(addr)));
    idx = (addr >> 2) % 16;
    for (int i = 0; i < nbeats; i++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        wv = 1'b0;
        @(posedge ACLK);
        #1;
      end
      d   = rnd ? $urandom : dbase + 32'(i);
      s   = rnd ? 4'($urandom) : sfix;
      wch = {d, s, (i == nbeats - 1)};
      wv  = 1'b1;
      for (int k = 0; k < 200; k++) begin
        @(negedge ACLK);
        if (wr) break;
      end
      if (!wr) chk("w_ready_timeout", 64'(wr), 64'd1);
      @(posedge ACLK);
      #1;
      if (i <= len) begin
`ifdef AXI_MEM_SLAVE_WSTRB_EN
        for (int b = 0; b < 4; b++)
          if (s[b]) mm[idx][b*8 +: 8] = d[b*8 +: 8];
`else
        mm[idx] = d;
`endif
      end
      idx = mnext(idx, bt, len);
    end
    wv = 1'b0;
    @(negedge ACLK);
    chk("b_valid_latency", 64'(bv), 64'd1);
    wait_drain("write");
  endtask

  task automatic do_read(input logic [0:0] id, input int len,
    input int bt, input int addr, input bit drain);
    int idx;
    logic [1:0] resp;
    resp = is_bad(bt, len) ? 2'b10 : 2'b00;
    idx  = (addr >> 2) % 16;
    for (int i = 0; i <= len; i++) begin
      rq.push_back({mm[idx], resp, (i == len), id});
      idx = mnext(idx, bt, len);
    end
    ar_send(ax(id, 8'(len), 2'(bt), 8'(addr)));
    @(negedge ACLK);
    chk("r_valid_latency", 64'(rv), 64'd1);
    if (drain) wait_drain("read");
  endtask

  initial begin
    logic [31:0] oldv;
    logic [31:0] newv;
    int len;
    int bt;
    int nb;
    n_chk  = 0;
    n_fail = 0;
    ARESET = 1'b1;
    awch = '0; awv = 1'b0;
    wch  = '0; wv  = 1'b0;
    arch = '0; arv = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_awready", 64'(awr), 64'd0);
    chk("rst_wready",  64'(wr),  64'd0);
    chk("rst_arready", 64'(arr), 64'd0);
    chk("rst_bvalid",  64'(bv),  64'd0);
    chk("rst_rvalid",  64'(rv),  64'd0);
    chk("rst_bch",     64'(bch), 64'd0);
    chk("rst_rch",     64'(rch), 64'd0);
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;

    do_write(0, 15, 1, 0, 16, 32'h0, 4'hF, 1'b1);
    do_write(1, 3, 1, 8'h04, 4, 32'hA0, 4'hF, 1'b0);
    do_read(1, 3, 1, 8'h04, 1'b1);
    do_read(0, 3, 2, 8'h08, 1'b1);
    do_write(0, 2, 0, 8'h14, 3, 32'hB0, 4'hF, 1'b0);
    do_read(0, 0, 1, 8'h14, 1'b1);
    do_write(1, 3, 1, 8'h20, 3, 32'hC0, 4'hF, 1'b0);
    do_write(0, 1, 3, 8'h30, 2, 32'hD0, 4'hF, 1'b0);
    do_write(1, 3, 1, 8'h00, 6, 32'hE0, 4'hF, 1'b0);
    do_write(0, 2, 2, 8'h18, 3, 32'hF0, 4'hF, 1'b0);
    do_read(1, 5, 3, 8'h34, 1'b1);
    do_read(0, 2, 2, 8'h3C, 1'b1);
    do_read(1, 15, 1, 8'h00, 1'b1);

    for (int t = 0; t < 30; t++) begin
      len = $urandom_range(0, 15);
      bt  = $urandom_range(0, 3);
      if (bt == 2 && $urandom_range(0, 1) == 1) len = 7;
      nb  = ($urandom_range(0, 3) != 0) ? len + 1
                                        : $urandom_range(1, 18);
      if ($urandom_range(0, 1) == 1)
        do_write(1'($urandom), len, bt, $urandom_range(0, 255),
                 nb, 32'h0, 4'hF, 1'b1);
      else
        do_read(1'($urandom), len, bt, $urandom_range(0, 255), 1'b1);
    end

    oldv = mm[3];
    newv = $urandom;
    bq.push_back(3'b000);
    aw_send(ax(0, 8'd0, 2'b01, 8'h0C));
    rq.push_back({oldv, 2'b00, 1'b1, 1'b1});
    wch  = {newv, 4'hF, 1'b1};
    wv   = 1'b1;
    arch = ax(1, 8'd0, 2'b01, 8'h0C);
    arv  = 1'b1;
    @(negedge ACLK);
    chk("concurrent_ready", 64'({wr, arr}), 64'd3);
    @(posedge ACLK);
    #1;
    wv  = 1'b0;
    arv = 1'b0;
    mm[3] = newv;
    wait_drain("concurrent");
    do_read(0, 0, 1, 8'h0C, 1'b1);

`ifdef AXI_MEM_SLAVE_WSTRB_EN
    do_write(0, 0, 1, 8'h24, 1, 32'hFFFFFFFF, 4'hF, 1'b0);
    do_write(0, 0, 1, 8'h24, 1, 32'h12345678, 4'h3, 1'b0);
    do_read(0, 0, 1, 8'h24, 1'b1);
`endif

    do_read(1, 7, 1, 8'h00, 1'b0);
    repeat (3) @(posedge ACLK);
    #1;
    ARESET = 1'b1;
    rq.delete();
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("midrst_rvalid",  64'(rv),  64'd0);
    chk("midrst_arready", 64'(arr), 64'd0);
    chk("midrst_rch",     64'(rch), 64'd0);
    @(negedge ACLK);
    chk("midrst_arready_rise", 64'(arr), 64'd1);
    @(posedge ACLK);
    #1;
    do_read(0, 3, 1, 8'h10, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
